button_conditioner: RTL and testbench

Multi-channel front-end conditioner for the datapath's user inputs (step/run buttons, switches). Each channel is synchronised, debounced with a configurable stability window, and turned into a clean level plus one-cycle press and release pulses. An optional auto-repeat mode emits periodic pulses while a button stays held. The block sits between the board pins and `datapath`, replacing the raw `i_button` connection with conditioned strobes.

---
 rtl/button_conditioner.sv | 206 ++++++++++++++++++++
 tb/tb_button_conditioner.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchroniser, debouncer and edge/repeat
// pulse generator for raw board inputs.
//
// Optional feature macro: BUTTON_AUTOREPEAT_EN
//   defined   - each channel gets a RELEASED/HELD/REPEATING FSM and a hold
//               counter that emits o_repeat pulses while the level stays high.
//   undefined - no FSM or hold counter; o_repeat is tied to 0 and
//               HOLD_CYCLES/REPEAT_CYCLES have no effect.

// One conditioned channel. Every channel is a separate instance with its own
// state, so the channels cannot interfere with each other.
module button_lane #(
    parameter int DEBOUNCE_CYCLES = 4
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    parameter int HOLD_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 8
`endif
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_button,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    // The counter saturates at DEBOUNCE_CYCLES-1. The edge that would take it
    // to DEBOUNCE_CYCLES toggles the level and clears the counter, so the
    // counter never wraps.
    localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic          level_q, level_d;
    logic          press_q, release_q;
    logic          flip, rise, fall;

    // Two-flop synchroniser on the asynchronous pin.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_button;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreements with the current level. Any agreement
    // restarts the count, so a short glitch leaves no trace.
    always_comb begin
        db_cnt_d = '0;
        flip     = 1'b0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                flip = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign level_d = level_q ^ flip;
    assign rise    = flip & ~level_q;
    assign fall    = flip &  level_q;

    // Level and edge pulses are registered together, so each pulse lines up
    // with the first cycle that shows the new level.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= rise;
            release_q <= fall;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        HELD      = 2'd1,
        REPEATING = 2'd2
    } rpt_state_e;

    rpt_state_e    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          repeat_q, repeat_d;

    // Repeat state register and pulse output.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= RELEASED;
            hold_cnt_q <= '0;
            repeat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            repeat_q   <= repeat_d;
        end
    end

    // The FSM follows the same rise/fall events that update the level, so the
    // press pulse and the start of the hold count land on the same edge. A
    // release is checked before an expiring count, so a release always
    // suppresses the repeat pulse in its own cycle.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        repeat_d   = 1'b0;
        case (state_q)
            RELEASED: begin
                if (rise) begin
                    state_d    = HELD;
                    hold_cnt_d = '0;
                end
            end
            HELD: begin
                if (fall) begin
                    state_d    = RELEASED;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    repeat_d   = 1'b1;
                    state_d    = REPEATING;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            REPEATING: begin
                if (fall) begin
                    state_d    = RELEASED;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == REP_LAST) begin
                    repeat_d   = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = RELEASED;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign o_repeat = repeat_q;
`else
    assign o_repeat = 1'b0;
`endif

endmodule

// Top level: one independent button_lane per input channel.
module button_conditioner #(
    parameter int CHANNELS        = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [CHANNELS-1:0] i_button,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release,
    output logic [CHANNELS-1:0] o_repeat
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        button_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_AUTOREPEAT_EN
            ,
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
        ) u_lane (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_button  (i_button[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_repeat  (o_repeat[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: expected press/release/repeat events are
// computed from the documented latencies when stimulus is driven, queued, and
// matched against the outputs every cycle by a monitor.
module tb_button_conditioner;

    localparam int CH   = 3;
    localparam int DB   = 4;
    localparam int HOLD = 16;
    localparam int REP  = 8;
    localparam int LAT  = DB + 2;   // cycles from driving a new value to the level change

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_REPEAT  = 2;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    logic          i_clk;
    logic          i_reset;
    logic [CH-1:0] i_button;
    logic [CH-1:0] o_level, o_press, o_release, o_repeat;

    int   cyc;
    int   checks;
    int   errors;
    ev_t  exp_q[$];

    logic [CH-1:0] exp_level;
    logic [CH-1:0] ep, er, et;

    button_conditioner #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_button  (i_button),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_repeat  (o_repeat)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Scoreboard monitor: pop every event due this cycle and compare all
    // outputs against the expectation; any stale entry was missed.
    initial exp_level = '0;
    always @(negedge i_clk) begin
        ep = '0;
        er = '0;
        et = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                case (exp_q[i].kind)
                    K_PRESS:   ep[exp_q[i].ch] = 1'b1;
                    K_RELEASE: er[exp_q[i].ch] = 1'b1;
                    default:   et[exp_q[i].ch] = 1'b1;
                endcase
                exp_q.delete(i);
            end else if (exp_q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event cyc=%0d ch=%0d kind=%0d got none required at cyc %0d",
                         cyc, exp_q[i].ch, exp_q[i].kind, exp_q[i].cyc);
                exp_q.delete(i);
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (ep[c]) exp_level[c] = 1'b1;
            if (er[c]) exp_level[c] = 1'b0;
        end
        if (!i_reset) exp_level = '0;
        checks++;
        if ({o_level, o_press, o_release, o_repeat} !== {exp_level, ep, er, et}) begin
            errors++;
            $display("FAIL scoreboard cyc=%0d got lvl=%b prs=%b rel=%b rpt=%b required lvl=%b prs=%b rel=%b rpt=%b",
                     cyc, o_level, o_press, o_release, o_repeat, exp_level, ep, er, et);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Button on channel ch driven high in cycle n and low again in cycle e.
    task automatic push_hold(input int ch, input int n, input int e);
        int p;
        int r;
        p = n + LAT;
        r = e + LAT;
        exp_q.push_back(ev_t'{p, ch, K_PRESS});
        exp_q.push_back(ev_t'{r, ch, K_RELEASE});
`ifdef BUTTON_AUTOREPEAT_EN
        for (int t = p + HOLD; t < r; t += REP) exp_q.push_back(ev_t'{t, ch, K_REPEAT});
`endif
    endtask

    task automatic test_reset();
        int n;
        i_reset  = 1'b0;
        i_button = '1;
        step(10);
        checks++;
        if ({o_level, o_press, o_release, o_repeat} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 0", {o_level, o_press, o_release, o_repeat});
        end
        n = cyc;
        i_reset = 1'b1;
        for (int c = 0; c < CH; c++) push_hold(c, n, n + 12);
        step(LAT - 1);
        checks++;
        if (o_level !== '0) begin
            errors++;
            $display("FAIL reset_level_early got %b required 000", o_level);
        end
        step(1);
        checks++;
        if (o_level !== '1 || o_press !== '1) begin
            errors++;
            $display("FAIL reset_fresh_press got lvl=%b prs=%b required 111/111", o_level, o_press);
        end
        step(12 - LAT);
        i_button = '0;
        step(20);
    endtask

    task automatic test_clean_press();
        int n;
        n = cyc;
        i_button[0] = 1'b1;
        push_hold(0, n, n + 10);
        step(10);
        i_button[0] = 1'b0;
        step(6);
        checks++;
        if (o_release[0] !== 1'b1 || o_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL clean_release got rel=%b lvl=%b required 1/0", o_release[0], o_level[0]);
        end
        step(20);
    endtask

    task automatic test_glitch();
        int n;
        // short high pulse on an idle channel
        i_button[1] = 1'b1;
        step(3);
        i_button[1] = 1'b0;
        step(20);
        checks++;
        if (o_level[1] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_high got lvl=%b required 0", o_level[1]);
        end
        // one-cycle dropout in the middle of a hold
        n = cyc;
        i_button[0] = 1'b1;
        push_hold(0, n, n + 20);
        step(10);
        i_button[0] = 1'b0;
        step(1);
        i_button[0] = 1'b1;
        step(LAT + 1);
        checks++;
        if (o_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_dropout got lvl=%b required 1", o_level[0]);
        end
        step(9 - LAT - 1);
        i_button[0] = 1'b0;
        step(30);
    endtask

    task automatic test_autorepeat();
        int n;
        n = cyc;
        i_button[0] = 1'b1;
        push_hold(0, n, n + 60);
        step(60);
        i_button[0] = 1'b0;
        step(30);
    endtask

    task automatic test_release_on_repeat();
        int n;
        n = cyc;
        i_button[0] = 1'b1;
        push_hold(0, n, n + HOLD + REP);   // release lands on P+HOLD+REP
        step(HOLD + REP);
        i_button[0] = 1'b0;
        step(LAT);
        checks++;
        if (o_release[0] !== 1'b1 || o_repeat[0] !== 1'b0) begin
            errors++;
            $display("FAIL release_wins got rel=%b rpt=%b required 1/0", o_release[0], o_repeat[0]);
        end
        step(30);
    endtask

    task automatic test_multichannel();
        int n;
        n = cyc;
        i_button[0] = 1'b1;
        push_hold(0, n, n + 12);
        step(3);
        i_button[2] = 1'b1;
        push_hold(2, n + 3, n + 15);
        step(9);
        i_button[0] = 1'b0;
        step(3);
        i_button[2] = 1'b0;
        step(25);
        checks++;
        if (o_level !== '0) begin
            errors++;
            $display("FAIL multi_idle got lvl=%b required 000", o_level);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int n;
        int m;
        n = cyc;
        i_button[0] = 1'b1;
        exp_q.push_back(ev_t'{n + LAT, 0, K_PRESS});
        step(7);
        i_button[2] = 1'b1;   // ch2 still debouncing when reset hits
        step(3);
        i_reset = 1'b0;
        #1;
        checks++;
        if ({o_level, o_press, o_release, o_repeat} !== '0) begin
            errors++;
            $display("FAIL async_reset got %b required 0", {o_level, o_press, o_release, o_repeat});
        end
        i_button[0] = 1'b0;
        step(4);
        m = cyc;
        i_reset = 1'b1;
        push_hold(2, m, m + 10);
        step(10);
        i_button[2] = 1'b0;
        step(25);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        i_reset  = 1'b0;
        i_button = '0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_autorepeat();
        test_release_on_repeat();
        test_multichannel();
        test_reset_mid_debounce();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
